// File: rtl/mem_region_ctrl_pkg.sv
// Shared types and the address-region decode rule for the memory region controller.
package mem_ctrl_pkg;

    // Controller FSM states; IDLE is the reset state and encodes as zero.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_IO   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Address regions seen by the CPU.
    typedef enum logic [1:0] {
        REG_MEM = 2'd0,
        REG_IO  = 2'd1,
        REG_ROM = 2'd2
    } region_e;

    // Widest address any instance may use; narrower addresses are zero-extended.
    localparam int MAX_ADDR_W = 64;

    // I/O match takes priority over the ROM range, so an I/O window placed
    // above ROM_BASE still decodes as I/O.
    function automatic region_e decode_region(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0] io_base,
        input logic [MAX_ADDR_W-1:0] io_mask,
        input logic [MAX_ADDR_W-1:0] rom_base
    );
        if ((addr & io_mask) == io_base) begin
            return REG_IO;
        end
        if (addr >= rom_base) begin
            return REG_ROM;
        end
        return REG_MEM;
    endfunction

endpackage

// File: rtl/mem_region_ctrl_if.sv
// CPU request/response channel. Both halves use valid/ready: a transfer
// happens on a rising edge where valid and ready are both high; the sender
// holds valid and its payload stable until that edge, and ready may be
// driven without waiting for valid.
interface mem_region_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cpu_req_valid;
    logic                cpu_req_ready;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic                cpu_req_we;
    logic [DATA_W-1:0]   cpu_req_wdata;
    logic [DATA_W/8-1:0] cpu_req_be;
    logic                cpu_rsp_valid;
    logic                cpu_rsp_ready;
    logic [DATA_W-1:0]   cpu_rsp_rdata;
    logic                cpu_rsp_err;

    // CPU side: issues requests, consumes responses.
    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_be,
        output cpu_rsp_ready,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err
    );

    // Controller side: accepts requests, produces responses.
    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_be,
        input  cpu_rsp_ready,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err
    );
endinterface

// File: rtl/mem_region_ctrl_decode.sv
// Combinational address-to-region decode with a ROM write-protection flag.
module mem_region_decode
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] IO_BASE  = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] IO_MASK  = 32'hFFF0_0000,
    parameter logic [ADDR_W-1:0] ROM_BASE = 32'hF100_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output region_e           region,
    output logic              rom_wr_violation
);

    // Region lookup and write-protection check.
    always_comb begin
        region           = decode_region(MAX_ADDR_W'(addr), MAX_ADDR_W'(IO_BASE),
                                         MAX_ADDR_W'(IO_MASK), MAX_ADDR_W'(ROM_BASE));
        rom_wr_violation = (region == REG_ROM) && we;
    end

endmodule

// File: rtl/mem_region_ctrl.sv
// Single-outstanding CPU request controller: decodes the address into memory,
// I/O or ROM, runs one bus access with a timeout, and returns a response.
module mem_region_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                IO_W     = 8,
    parameter logic [ADDR_W-1:0] IO_BASE  = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] IO_MASK  = 32'hFFF0_0000,
    parameter logic [ADDR_W-1:0] ROM_BASE = 32'hF100_0000,
    parameter int                TIMEOUT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_region_ctrl_if.slave    cpu,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                cache_enable,
    output logic                io_req,
    output logic                io_we,
    output logic [7:0]          io_addr,
    output logic [IO_W-1:0]     io_wdata,
    input  logic                io_ack,
    input  logic [IO_W-1:0]     io_rdata,
    output state_e              dbg_state
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state;
    state_e              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                accept;
    logic                load_rsp;
    logic [DATA_W-1:0]   rsp_rdata_next;
    logic                rsp_err_next;
    region_e             region;
    logic                rom_wr_violation;

    mem_region_decode #(
        .ADDR_W   (ADDR_W),
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK),
        .ROM_BASE (ROM_BASE)
    ) u_decode (
        .addr             (cpu.cpu_req_addr),
        .we               (cpu.cpu_req_we),
        .region           (region),
        .rom_wr_violation (rom_wr_violation)
    );

    // Next state, timeout counter update and response capture decisions.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        accept         = 1'b0;
        load_rsp       = 1'b0;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.cpu_req_valid) begin
                    accept   = 1'b1;
                    cnt_next = '0;
                    if (region == REG_IO) begin
                        state_next = ST_IO;
                    end else if (rom_wr_violation) begin
                        // ROM write: answer immediately, never touch a bus.
                        state_next   = ST_RESP;
                        load_rsp     = 1'b1;
                        rsp_err_next = 1'b1;
                    end else begin
                        state_next = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                // Ack beats the timeout when both land in the same cycle.
                if (mem_ack) begin
                    state_next     = ST_RESP;
                    load_rsp       = 1'b1;
                    rsp_rdata_next = we_q ? '0 : mem_rdata;
                end else if (cnt == CNT_LAST) begin
                    state_next   = ST_RESP;
                    load_rsp     = 1'b1;
                    rsp_err_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_IO: begin
                if (io_ack) begin
                    state_next     = ST_RESP;
                    load_rsp       = 1'b1;
                    rsp_rdata_next = we_q ? '0 : DATA_W'(io_rdata);
                end else if (cnt == CNT_LAST) begin
                    state_next   = ST_RESP;
                    load_rsp     = 1'b1;
                    rsp_err_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (cpu.cpu_rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch: holds the accepted request fields stable for the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            addr_q  <= cpu.cpu_req_addr;
            we_q    <= cpu.cpu_req_we;
            wdata_q <= cpu.cpu_req_wdata;
            be_q    <= cpu.cpu_req_be;
        end
    end

    // Timeout counter: cycles spent waiting for ack in the current access.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Response registers, held until the CPU takes the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (load_rsp) begin
            rsp_rdata_q <= rsp_rdata_next;
            rsp_err_q   <= rsp_err_next;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cpu.cpu_req_ready = (state == ST_IDLE);
        cpu.cpu_rsp_valid = (state == ST_RESP);
        cpu.cpu_rsp_rdata = rsp_rdata_q;
        cpu.cpu_rsp_err   = rsp_err_q;
        mem_req           = (state == ST_MEM);
        mem_we            = (state == ST_MEM) && we_q;
        mem_addr          = addr_q;
        mem_wdata         = wdata_q;
        mem_be            = be_q;
        cache_enable      = (state == ST_MEM) && (addr_q < IO_BASE);
        io_req            = (state == ST_IO);
        io_we             = (state == ST_IO) && we_q;
        io_addr           = addr_q[7:0];
        io_wdata          = wdata_q[IO_W-1:0];
        dbg_state         = state;
    end

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Bench for mem_region_ctrl: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_region_ctrl;
    import mem_ctrl_pkg::*;

    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] IO_BASE  = 32'hF000_0000;
    localparam logic [31:0] IO_MASK  = 32'hFFF0_0000;
    localparam logic [31:0] ROM_BASE = 32'hF100_0000;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, cache_enable;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        io_req, io_we, io_ack;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    state_e      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    mem_region_ctrl_if #(.ADDR_W(32), .DATA_W(32)) cpu ();

    mem_region_ctrl #(
        .ADDR_W(32), .DATA_W(32), .IO_W(8), .IO_BASE(IO_BASE), .IO_MASK(IO_MASK),
        .ROM_BASE(ROM_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cpu(cpu),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cache_enable(cache_enable),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .dbg_state(dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: region rules straight from the address map.
    function automatic bit ref_is_io(input logic [31:0] a);
        return (a & IO_MASK) == IO_BASE;
    endfunction

    function automatic bit ref_is_rom(input logic [31:0] a);
        return !ref_is_io(a) && (a >= ROM_BASE);
    endfunction

    // One full transaction. Starts and ends at a falling edge with the DUT idle.
    // ack_at: cycle (1-based after acceptance) the owning bus acks; > TIMEOUT means never.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, input int ack_at, input logic [31:0] bus_rdata,
                          input int rsp_wait, input bit stray);
        bit          is_io, rom_wr, acked;
        int          n_req;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_rdata_q[$];
        is_io  = ref_is_io(addr);
        rom_wr = ref_is_rom(addr) && we;
        acked  = !rom_wr && (ack_at >= 1) && (ack_at <= TIMEOUT);
        n_req  = rom_wr ? 0 : (acked ? ack_at : TIMEOUT);
        exp_err = !acked;
        if (!acked || we) exp_rdata = 32'h0;
        else if (is_io)   exp_rdata = {24'h0, bus_rdata[7:0]};
        else              exp_rdata = bus_rdata;
        exp_rdata_q.push_back(exp_rdata);

        check_eq("req_ready_idle", cpu.cpu_req_ready, 1);
        cpu.cpu_req_valid = 1'b1;
        cpu.cpu_req_addr  = addr;
        cpu.cpu_req_we    = we;
        cpu.cpu_req_wdata = wdata;
        cpu.cpu_req_be    = be;
        @(negedge clk);
        cpu.cpu_req_valid = 1'b0;
        cpu.cpu_req_addr  = $urandom();
        cpu.cpu_req_we    = 1'($urandom_range(0, 1));
        cpu.cpu_req_wdata = $urandom();
        cpu.cpu_req_be    = 4'($urandom());

        for (int c = 1; c <= n_req; c++) begin
            check_eq("rsp_valid_busy", cpu.cpu_rsp_valid, 0);
            check_eq("req_ready_busy", cpu.cpu_req_ready, 0);
            if (is_io) begin
                check_eq("io_req", io_req, 1);
                check_eq("mem_req_in_io", mem_req, 0);
                check_eq("io_addr", io_addr, addr[7:0]);
                check_eq("io_we", io_we, we);
                check_eq("io_wdata", io_wdata, wdata[7:0]);
                io_ack   = (c == ack_at);
                io_rdata = (c == ack_at) ? bus_rdata[7:0] : 8'($urandom());
                mem_ack  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                check_eq("mem_req", mem_req, 1);
                check_eq("io_req_in_mem", io_req, 0);
                check_eq("mem_addr", mem_addr, addr);
                check_eq("mem_we", mem_we, we);
                check_eq("mem_wdata", mem_wdata, wdata);
                check_eq("mem_be", mem_be, be);
                check_eq("cache_enable", cache_enable, addr < IO_BASE);
                mem_ack   = (c == ack_at);
                mem_rdata = (c == ack_at) ? bus_rdata : $urandom();
                io_ack    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end

        // Late acks while the response is pending must be ignored.
        mem_ack   = stray;
        io_ack    = stray;
        mem_rdata = $urandom();
        io_rdata  = 8'($urandom());
        exp_rdata = exp_rdata_q.pop_front();
        check_eq("mem_req_resp", mem_req, 0);
        check_eq("io_req_resp", io_req, 0);
        check_eq("cache_en_resp", cache_enable, 0);
        check_eq("rsp_valid", cpu.cpu_rsp_valid, 1);
        check_eq("rsp_rdata", cpu.cpu_rsp_rdata, exp_rdata);
        check_eq("rsp_err", cpu.cpu_rsp_err, exp_err);
        for (int w = 0; w < rsp_wait; w++) begin
            @(negedge clk);
            check_eq("rsp_valid_hold", cpu.cpu_rsp_valid, 1);
            check_eq("rsp_rdata_hold", cpu.cpu_rsp_rdata, exp_rdata);
            check_eq("rsp_err_hold", cpu.cpu_rsp_err, exp_err);
            check_eq("req_ready_hold", cpu.cpu_req_ready, 0);
        end
        cpu.cpu_rsp_ready = 1'b1;
        @(negedge clk);
        cpu.cpu_rsp_ready = 1'b0;
        mem_ack = 1'b0;
        io_ack  = 1'b0;
        check_eq("rsp_valid_done", cpu.cpu_rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] a;
        cpu.cpu_req_valid = 1'b0;
        cpu.cpu_req_addr  = '0;
        cpu.cpu_req_we    = 1'b0;
        cpu.cpu_req_wdata = '0;
        cpu.cpu_req_be    = '0;
        cpu.cpu_rsp_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; io_ack = 1'b0; io_rdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check_eq("rst_req_ready", cpu.cpu_req_ready, 1);
        check_eq("rst_rsp_valid", cpu.cpu_rsp_valid, 0);
        check_eq("rst_rsp_rdata", cpu.cpu_rsp_rdata, 0);
        check_eq("rst_rsp_err", cpu.cpu_rsp_err, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_io_req", io_req, 0);
        check_eq("rst_cache_en", cache_enable, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);

        // Directed cases.
        do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(32'hF000_0044, 1'b1, 32'h1234_56A5, 4'b0001, 1, 32'h0, 0, 1'b0);
        do_txn(32'hF000_0044, 1'b0, 32'h0, 4'hF, 2, 32'hFFFF_FF5A, 0, 1'b0);
        do_txn(32'hF100_0000, 1'b1, 32'h5555_AAAA, 4'hF, 1, 32'h0, 0, 1'b1);
        do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, 99, 32'h0, 0, 1'b1);
        do_txn(32'h0000_2000, 1'b0, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 5, 1'b0);
        do_txn(32'h0000_2004, 1'b1, 32'h0BAD_C0DE, 4'b1010, TIMEOUT, 32'h1111_2222, 0, 1'b0);
        do_txn(32'hF00F_FFFF, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'h0000_00C3, 0, 1'b1);
        do_txn(32'hF010_0000, 1'b0, 32'h0, 4'hF, 1, 32'h7654_3210, 0, 1'b0);
        do_txn(32'hEFFF_FFFF, 1'b1, 32'hAAAA_5555, 4'b0110, 4, 32'h0, 1, 1'b0);
        do_txn(32'hF100_0000, 1'b0, 32'h0, 4'hF, 2, 32'h1357_9BDF, 0, 1'b0);
        do_txn(32'hF0FF_FFFF, 1'b1, 32'h0, 4'hF, TIMEOUT + 1, 32'h0, 0, 1'b0);

        // Reset in the middle of a memory access.
        cpu.cpu_req_valid = 1'b1;
        cpu.cpu_req_addr  = 32'h0000_3000;
        cpu.cpu_req_we    = 1'b0;
        @(negedge clk);
        cpu.cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_mem_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_mem_req", mem_req, 0);
        check_eq("midrst_rsp_valid", cpu.cpu_rsp_valid, 0);
        check_eq("midrst_req_ready", cpu.cpu_req_ready, 1);
        do_txn(32'h0000_3000, 1'b0, 32'h0, 4'hF, 2, 32'h2468_ACE0, 0, 1'b0);

        // Randomized transactions across all regions.
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(32'hEFFF_FFFF, 32'h0);
                1:       a = 32'hF000_0000 | $urandom_range(32'h000F_FFFF, 32'h0);
                2:       a = $urandom_range(32'hF0FF_FFFF, 32'hF010_0000);
                default: a = $urandom_range(32'hFFFF_FFFF, 32'hF100_0000);
            endcase
            do_txn(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom()),
                   $urandom_range(1, TIMEOUT + 2), $urandom(), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
